// File: rtl/button_debounce_pair_if.sv
// Purpose: bundles the two raw button inputs and their conditioned outputs.
// Latency: none; this is wiring only.
// Backpressure: none; every signal is a plain level or a one-cycle pulse.
//
// Signals:
//   btn1, btn2                  raw active-low buttons (0 = pressed), asynchronous
//   btn1_db, btn2_db            debounced levels, active-low like the raw inputs
//   btn1_press, btn2_press      one-cycle pulse when the debounced level goes 1->0
//   btn1_release, btn2_release  one-cycle pulse when the debounced level goes 0->1
// Modports: master drives the raw buttons and observes the results;
//           slave is the conditioner itself.
interface button_debounce_pair_if;
  logic btn1;
  logic btn2;
  logic btn1_db;
  logic btn2_db;
  logic btn1_press;
  logic btn1_release;
  logic btn2_press;
  logic btn2_release;

  modport master (
    output btn1,
    output btn2,
    input  btn1_db,
    input  btn2_db,
    input  btn1_press,
    input  btn1_release,
    input  btn2_press,
    input  btn2_release
  );

  modport slave (
    input  btn1,
    input  btn2,
    output btn1_db,
    output btn2_db,
    output btn1_press,
    output btn1_release,
    output btn2_press,
    output btn2_release
  );
endinterface

// File: rtl/button_debounce_pair.sv
// Purpose: two independent push-button conditioners (sync + debounce + edge pulses).
// Latency: a clean raw edge at cycle t moves the debounced level at edge t+DEBOUNCE_CYCLES+3.
// Backpressure: none; outputs are free-running registered levels and pulses.
//
// Ports:
//   clk   system clock, single domain
//   rst   synchronous active-high reset; forces every channel to "released"
//   bus   button_debounce_pair_if.slave: raw btn1/btn2 in; *_db levels and
//         *_press / *_release one-cycle pulses out
module button_debounce_pair #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int CNT_W           = 19
) (
  input  logic                         clk,
  input  logic                         rst,
  button_debounce_pair_if.slave        bus
);

  // REL/WAIT_P present db=1, PRS/WAIT_R present db=0.
  typedef enum logic [1:0] {
    REL    = 2'b00,
    WAIT_P = 2'b01,
    PRS    = 2'b10,
    WAIT_R = 2'b11
  } state_t;

  // Last counter value before a level is accepted; the counter never
  // exceeds this, so it cannot wrap.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0] raw;
  logic [1:0] db;
  logic [1:0] press;
  logic [1:0] rel;

  assign raw = {bus.btn2, bus.btn1};

  for (genvar g = 0; g < 2; g++) begin : g_chan
    logic             s1;
    logic             s2;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             db_q;
    logic             db_d;
    logic             press_q;
    logic             press_d;
    logic             rel_q;
    logic             rel_d;

    // Two-flop synchroniser; resets to the released level so a held button
    // is seen as a fresh press once reset lifts.
    always_ff @(posedge clk) begin
      if (rst) begin
        s1 <= 1'b1;
        s2 <= 1'b1;
      end else begin
        s1 <= raw[g];
        s2 <= s1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= REL;
        cnt_q   <= '0;
        db_q    <= 1'b1;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        db_q    <= db_d;
        press_q <= press_d;
        rel_q   <= rel_d;
      end
    end

    // Any reversal of s2 while waiting drops back to the settled state with
    // the counter cleared, so the full count restarts on the next change.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      case (state_q)
        REL: begin
          if (!s2) begin
            state_d = WAIT_P;
            cnt_d   = '0;
          end
        end
        WAIT_P: begin
          if (s2) begin
            state_d = REL;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = PRS;
            press_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PRS: begin
          if (s2) begin
            state_d = WAIT_R;
            cnt_d   = '0;
          end
        end
        WAIT_R: begin
          if (!s2) begin
            state_d = PRS;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = REL;
            rel_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = REL;
          cnt_d   = '0;
        end
      endcase
      // The db flop follows the next state so the level and its pulse
      // change on the same edge.
      db_d = (state_d == REL) || (state_d == WAIT_P);
    end

    assign db[g]    = db_q;
    assign press[g] = press_q;
    assign rel[g]   = rel_q;
  end

  assign bus.btn1_db      = db[0];
  assign bus.btn2_db      = db[1];
  assign bus.btn1_press   = press[0];
  assign bus.btn2_press   = press[1];
  assign bus.btn1_release = rel[0];
  assign bus.btn2_release = rel[1];

endmodule

// File: tb/tb_button_debounce_pair.sv
module tb_button_debounce_pair;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  button_debounce_pair_if bus();

  button_debounce_pair #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // Reference model: a level is accepted once D+1 consecutive synchronised
  // samples disagree with the current debounced level; s2 is the raw input
  // delayed by two clocks.
  bit       m_valid = 1'b0;
  bit [1:0] m_s1 = 2'b11, m_s2 = 2'b11, m_db = 2'b11, m_pr = 2'b00, m_rl = 2'b00;
  int       m_run [2] = '{0, 0};

  always @(posedge clk) begin
    bit [1:0] r;
    r = {bus.btn2, bus.btn1};
    for (int c = 0; c < 2; c++) begin
      m_pr[c] = 1'b0;
      m_rl[c] = 1'b0;
      if (rst) begin
        m_s1[c] = 1'b1;
        m_s2[c] = 1'b1;
        m_db[c] = 1'b1;
        m_run[c] = 0;
      end else begin
        if (m_s2[c] != m_db[c]) m_run[c] = m_run[c] + 1;
        else m_run[c] = 0;
        if (m_run[c] == D + 1) begin
          m_db[c] = m_s2[c];
          if (m_s2[c] == 1'b0) m_pr[c] = 1'b1;
          else m_rl[c] = 1'b1;
          m_run[c] = 0;
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = r[c];
      end
    end
    if (rst) m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("mdl btn1_db",      bus.btn1_db,      m_db[0]);
      chk("mdl btn2_db",      bus.btn2_db,      m_db[1]);
      chk("mdl btn1_press",   bus.btn1_press,   m_pr[0]);
      chk("mdl btn2_press",   bus.btn2_press,   m_pr[1]);
      chk("mdl btn1_release", bus.btn1_release, m_rl[0]);
      chk("mdl btn2_release", bus.btn2_release, m_rl[1]);
    end
  end

  // Park on the falling edge that follows rising edge n.
  task automatic at_edge(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic idle1(input string tag);
    chk({tag, " btn1_db"}, bus.btn1_db, 1'b1);
    chk({tag, " btn1_press"}, bus.btn1_press, 1'b0);
  endtask

  int hold [2];

  initial begin
    rst = 1'b1;
    bus.btn1 = 1'b1;
    bus.btn2 = 1'b1;

    // Reset held for two edges.
    for (int e = 1; e <= 2; e++) begin
      at_edge(e);
      chk("rst btn1_db", bus.btn1_db, 1'b1);
      chk("rst btn2_db", bus.btn2_db, 1'b1);
      chk("rst btn1_press", bus.btn1_press, 1'b0);
      chk("rst btn2_release", bus.btn2_release, 1'b0);
    end
    rst = 1'b0;

    // Clean press.
    at_edge(10); bus.btn1 = 1'b0;
    at_edge(16); idle1("press pre");
    at_edge(17);
    chk("press btn1_db", bus.btn1_db, 1'b0);
    chk("press btn1_press", bus.btn1_press, 1'b1);
    chk("press btn2_db", bus.btn2_db, 1'b1);
    chk("press btn2_press", bus.btn2_press, 1'b0);
    at_edge(18);
    chk("press pulse end", bus.btn1_press, 1'b0);
    chk("press held db", bus.btn1_db, 1'b0);

    // Release.
    at_edge(40); bus.btn1 = 1'b1;
    at_edge(46);
    chk("rel pre db", bus.btn1_db, 1'b0);
    chk("rel pre pulse", bus.btn1_release, 1'b0);
    at_edge(47);
    chk("rel btn1_db", bus.btn1_db, 1'b1);
    chk("rel btn1_release", bus.btn1_release, 1'b1);
    at_edge(48);
    chk("rel pulse end", bus.btn1_release, 1'b0);

    // Bounce then settle low from cycle 54.
    for (int e = 50; e <= 54; e++) begin
      at_edge(e);
      bus.btn1 = (e % 2 == 1);
    end
    for (int e = 55; e <= 60; e++) begin
      at_edge(e); idle1("bounce hold");
    end
    at_edge(61);
    chk("bounce btn1_db", bus.btn1_db, 1'b0);
    chk("bounce btn1_press", bus.btn1_press, 1'b1);
    at_edge(70); bus.btn1 = 1'b1;
    at_edge(77);
    chk("bounce rel", bus.btn1_release, 1'b1);

    // Three-cycle glitch must be ignored.
    at_edge(90); bus.btn1 = 1'b0;
    at_edge(93); bus.btn1 = 1'b1;
    for (int e = 94; e <= 102; e++) begin
      at_edge(e); idle1("glitch");
    end

    // Simultaneous press, then independent release.
    at_edge(110); bus.btn1 = 1'b0; bus.btn2 = 1'b0;
    at_edge(117);
    chk("sim btn1_db", bus.btn1_db, 1'b0);
    chk("sim btn2_db", bus.btn2_db, 1'b0);
    chk("sim btn1_press", bus.btn1_press, 1'b1);
    chk("sim btn2_press", bus.btn2_press, 1'b1);
    at_edge(130); bus.btn2 = 1'b1;
    at_edge(137);
    chk("sim btn2 rel db", bus.btn2_db, 1'b1);
    chk("sim btn2 rel pulse", bus.btn2_release, 1'b1);
    chk("sim btn1 kept", bus.btn1_db, 1'b0);
    at_edge(140); bus.btn1 = 1'b1;
    at_edge(147);
    chk("sim btn1 rel", bus.btn1_release, 1'b1);

    // Reset while counting; held button becomes a fresh press.
    at_edge(160); bus.btn1 = 1'b0;
    at_edge(164); rst = 1'b1;
    at_edge(165); rst = 1'b0;
    for (int e = 165; e <= 171; e++) begin
      at_edge(e); idle1("rstmid");
    end
    at_edge(172);
    chk("rstmid btn1_db", bus.btn1_db, 1'b0);
    chk("rstmid btn1_press", bus.btn1_press, 1'b1);
    at_edge(180); bus.btn1 = 1'b1;

    // Randomised phase: hold lengths straddle the D+1 acceptance window,
    // with occasional resets.
    at_edge(200);
    hold[0] = 0;
    hold[1] = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      if (hold[0] == 0) begin
        bus.btn1 = ~bus.btn1;
        hold[0] = $urandom_range(1, 10);
      end else hold[0]--;
      if (hold[1] == 0) begin
        bus.btn2 = ~bus.btn2;
        hold[1] = $urandom_range(1, 10);
      end else hold[1]--;
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
